// File: rtl/rgb_seq_pkg.sv
// Shared types and helpers for the RGB fade sequencer.
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    HOLD
  } seq_state_e;

  localparam int unsigned WIDTH_DEF = 8;

  function automatic int unsigned key_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgb_ramp_channel.sv
// One duty-level register that steps by one LSB toward a target, or loads a
// pass-through value.
module rgb_ramp_channel
  import rgb_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_target,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_level,
  output logic             o_at_target
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_level;
    if (i_step) begin
      if (r_level < i_target) begin
        w_next = r_level + ONE;
      end else if (r_level > i_target) begin
        w_next = r_level - ONE;
      end
    end
  end

  // Compare the post-step level so RAMP ends on the edge the last step lands.
  assign o_at_target = (w_next == i_target);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= '0;
    end else if (i_load) begin
      r_level <= i_load_val;
    end else begin
      r_level <= w_next;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Keyframe fade sequencer: ramps three duty levels through a host-written
// colour table, holding at each key, with bumpless encoder pass-through.
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned DIV_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         seq_sel,
  input  logic [WIDTH-1:0]             enc_level0,
  input  logic [WIDTH-1:0]             enc_level1,
  input  logic [WIDTH-1:0]             enc_level2,
  input  logic                         key_we,
  input  logic [key_w(NUM_KEYS)-1:0]   key_addr,
  input  logic [3*WIDTH-1:0]           key_rgb,
  input  logic [DIV_W-1:0]             step_div,
  input  logic [7:0]                   hold_steps,
  output logic [WIDTH-1:0]             level0,
  output logic [WIDTH-1:0]             level1,
  output logic [WIDTH-1:0]             level2,
  output logic [key_w(NUM_KEYS)-1:0]   key_idx,
  output logic                         busy
);

  localparam int unsigned KW = key_w(NUM_KEYS);

  seq_state_e         r_state;
  seq_state_e         w_state_nx;
  logic [3*WIDTH-1:0] r_table [NUM_KEYS];
  logic [KW-1:0]      r_key_idx;
  logic [DIV_W-1:0]   r_presc;
  logic [7:0]         r_hold;
  logic               r_busy;

  logic               w_run;
  logic               w_tick;
  logic               w_step;
  logic [2:0]         w_at;
  logic               w_hold_clr;
  logic               w_hold_inc;
  logic               w_key_adv;
  logic [3*WIDTH-1:0] w_tgt;

  assign w_tgt  = r_table[r_key_idx];
  assign w_run  = enable & seq_sel;
  assign w_tick = w_run && (r_state != IDLE) && (r_presc >= step_div);
  assign w_step = w_tick && (r_state == RAMP);

  always_comb begin
    w_state_nx = r_state;
    w_hold_clr = 1'b0;
    w_hold_inc = 1'b0;
    w_key_adv  = 1'b0;
    if (!w_run) begin
      w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_nx = RAMP;
        RAMP: begin
          if (&w_at) begin
            w_state_nx = HOLD;
            w_hold_clr = 1'b1;
          end
        end
        HOLD: begin
          if (w_tick) begin
            if (r_hold == hold_steps) begin
              w_key_adv  = 1'b1;
              w_state_nx = RAMP;
            end else begin
              w_hold_inc = 1'b1;
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_hold    <= '0;
      r_key_idx <= '0;
      r_busy    <= 1'b0;
      r_table   <= '{default: '0};
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (r_state == RAMP);
      // Prescaler keeps its phase across RAMP/HOLD; it restarts only from IDLE.
      if (r_state == IDLE) begin
        if (w_state_nx == RAMP) r_presc <= '0;
      end else if (w_run) begin
        r_presc <= w_tick ? '0 : r_presc + DIV_W'(1);
      end
      if (w_hold_clr) begin
        r_hold <= '0;
      end else if (w_hold_inc) begin
        r_hold <= r_hold + 8'd1;
      end
      if (w_key_adv) r_key_idx <= r_key_idx + KW'(1);
      if (key_we) r_table[key_addr] <= key_rgb;
    end
  end

  rgb_ramp_channel #(.WIDTH(WIDTH)) u_ch0 (
    .clk        (clk),
    .reset      (reset),
    .i_step     (w_step),
    .i_target   (w_tgt[WIDTH-1:0]),
    .i_load     (~seq_sel),
    .i_load_val (enc_level0),
    .o_level    (level0),
    .o_at_target(w_at[0])
  );

  rgb_ramp_channel #(.WIDTH(WIDTH)) u_ch1 (
    .clk        (clk),
    .reset      (reset),
    .i_step     (w_step),
    .i_target   (w_tgt[2*WIDTH-1:WIDTH]),
    .i_load     (~seq_sel),
    .i_load_val (enc_level1),
    .o_level    (level1),
    .o_at_target(w_at[1])
  );

  rgb_ramp_channel #(.WIDTH(WIDTH)) u_ch2 (
    .clk        (clk),
    .reset      (reset),
    .i_step     (w_step),
    .i_target   (w_tgt[3*WIDTH-1:2*WIDTH]),
    .i_load     (~seq_sel),
    .i_load_val (enc_level2),
    .o_level    (level2),
    .o_at_target(w_at[2])
  );

  assign key_idx = r_key_idx;
  assign busy    = r_busy;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed and randomized checks of rgb_fade_sequencer against a segment-level
// timing model built from keyframe distances, step period and hold length.
`timescale 1ns/1ps
module tb_rgb_fade_sequencer;

  localparam int NK = 4;

  logic        clk = 1'b0;
  logic        reset, enable, seq_sel, key_we;
  logic [7:0]  enc0, enc1, enc2;
  logic [1:0]  key_addr;
  logic [23:0] key_rgb;
  logic [15:0] step_div;
  logic [7:0]  hold_steps;
  logic [7:0]  level0, level1, level2;
  logic [1:0]  key_idx;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int keys [NK][3];

  always #5 clk = ~clk;

  rgb_fade_sequencer #(.NUM_KEYS(4), .WIDTH(8), .DIV_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .seq_sel   (seq_sel),
    .enc_level0(enc0),
    .enc_level1(enc1),
    .enc_level2(enc2),
    .key_we    (key_we),
    .key_addr  (key_addr),
    .key_rgb   (key_rgb),
    .step_div  (step_div),
    .hold_steps(hold_steps),
    .level0    (level0),
    .level1    (level1),
    .level2    (level2),
    .key_idx   (key_idx),
    .busy      (busy)
  );

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; seq_sel = 1'b1; key_we = 1'b0;
    cyc1(); cyc1();
    reset = 1'b0;
    for (int a = 0; a < NK; a++) for (int c = 0; c < 3; c++) keys[a][c] = 0;
  endtask

  task automatic write_key(input int a, input int c0, input int c1, input int c2);
    key_we = 1'b1; key_addr = 2'(a); key_rgb = {8'(c2), 8'(c1), 8'(c0)};
    cyc1();
    key_we = 1'b0;
    keys[a][0] = c0; keys[a][1] = c1; keys[a][2] = c2;
  endtask

  // Expected per-cycle outputs: each segment is a ramp whose level after n
  // cycles is start +/- min(distance, n/period), followed by a fixed hold.
  task automatic run_model(input string tag, input int nseg,
                           input int l0, input int l1, input int l2, input int k0);
    int q0[$], q1[$], q2[$], qk[$], qr[$];
    int lv[3], tg[3], v[3];
    int k, s, per, rl, hl, d, ad, m;
    lv[0] = l0; lv[1] = l1; lv[2] = l2;
    k = k0;
    per = int'(step_div) + 1;
    for (int g = 0; g < nseg; g++) begin
      s = 0;
      for (int c = 0; c < 3; c++) begin
        tg[c] = keys[k][c];
        ad = (tg[c] > lv[c]) ? tg[c] - lv[c] : lv[c] - tg[c];
        if (ad > s) s = ad;
      end
      rl = (s == 0) ? 1 : s * per;
      for (int n = 0; n < rl; n++) begin
        for (int c = 0; c < 3; c++) begin
          d  = tg[c] - lv[c];
          ad = (d < 0) ? -d : d;
          m  = (n / per < ad) ? n / per : ad;
          v[c] = (d < 0) ? lv[c] - m : lv[c] + m;
        end
        q0.push_back(v[0]); q1.push_back(v[1]); q2.push_back(v[2]);
        qk.push_back(k); qr.push_back(1);
      end
      lv = tg;
      hl = (int'(hold_steps) + 1) * per;
      for (int n = 0; n < hl; n++) begin
        q0.push_back(lv[0]); q1.push_back(lv[1]); q2.push_back(lv[2]);
        qk.push_back(k); qr.push_back(0);
      end
      k = (k + 1) % NK;
    end
    enable = 1'b1; seq_sel = 1'b1;
    cyc1();
    for (int i = 0; i < q0.size(); i++) begin
      chk({tag, "_lvl0"}, i, level0, q0[i]);
      chk({tag, "_lvl1"}, i, level1, q1[i]);
      chk({tag, "_lvl2"}, i, level2, q2[i]);
      chk({tag, "_key"},  i, key_idx, qk[i]);
      chk({tag, "_busy"}, i, busy, (i == 0) ? 0 : qr[i-1]);
      cyc1();
    end
    enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; seq_sel = 1'b1; key_we = 1'b0;
    key_addr = '0; key_rgb = '0; enc0 = '0; enc1 = '0; enc2 = '0;
    step_div = '0; hold_steps = '0;

    do_reset();
    chk("rst_lvl0", 0, level0, 0);
    chk("rst_lvl1", 0, level1, 0);
    chk("rst_lvl2", 0, level2, 0);
    chk("rst_key",  0, key_idx, 0);
    chk("rst_busy", 0, busy, 0);

    // Single ramp to (10,0,5) at one step per cycle.
    step_div = 16'd0; hold_steps = 8'd3;
    write_key(0, 10, 0, 5);
    run_model("single", 1, 0, 0, 0, 0);

    // Prescaler and hold: 4-cycle steps, 12-cycle hold, then ramp down.
    do_reset();
    step_div = 16'd3; hold_steps = 8'd2;
    write_key(0, 4, 4, 4);
    write_key(1, 0, 0, 0);
    run_model("presc", 2, 0, 0, 0, 0);

    // Randomized tables and timing, running through the key_idx wrap.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      step_div   = 16'($urandom_range(0, 2));
      hold_steps = 8'($urandom_range(0, 3));
      for (int a = 0; a < NK; a++)
        write_key(a, 1 + 4 * a + int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
      run_model("rand", 5, 0, 0, 0, 0);
    end

    // Reset mid-ramp, with a key write during reset that must be dropped.
    do_reset();
    step_div = 16'd0; hold_steps = 8'd0;
    write_key(0, 50, 60, 70);
    enable = 1'b1; seq_sel = 1'b1;
    repeat (5) cyc1();
    reset = 1'b1; key_we = 1'b1; key_addr = 2'd1; key_rgb = 24'h0A0B0C;
    cyc1();
    chk("mid_rst_lvl0", 0, level0, 0);
    chk("mid_rst_lvl1", 0, level1, 0);
    chk("mid_rst_lvl2", 0, level2, 0);
    chk("mid_rst_key",  0, key_idx, 0);
    chk("mid_rst_busy", 0, busy, 0);
    reset = 1'b0; key_we = 1'b0; enable = 1'b0;
    for (int a = 0; a < NK; a++) for (int c = 0; c < 3; c++) keys[a][c] = 0;
    cyc1();
    run_model("zero", 3, 0, 0, 0, 0);

    // Bumpless handover from encoder levels.
    do_reset();
    step_div = 16'd0; hold_steps = 8'd1;
    enable = 1'b1; seq_sel = 1'b0;
    enc0 = 8'd200; enc1 = 8'd100; enc2 = 8'd50;
    cyc1();
    chk("pass_lvl0", 0, level0, 200);
    chk("pass_lvl1", 0, level1, 100);
    chk("pass_lvl2", 0, level2, 50);
    write_key(0, 202, 100, 50);
    enc0 = 8'd7; enc1 = 8'd7; enc2 = 8'd7;
    run_model("bump", 1, 200, 100, 50, 0);

    // Live edit of the current target while ramping.
    do_reset();
    step_div = 16'd0; hold_steps = 8'd255;
    write_key(0, 100, 0, 0);
    enable = 1'b1; seq_sel = 1'b1;
    for (int n = 0; n < 200 && level0 != 8'd30; n++) cyc1();
    chk("live_reach", 0, level0, 30);
    write_key(0, 20, 0, 0);
    chk("live_old_tgt", 1, level0, 31);
    repeat (11) cyc1();
    chk("live_settle", 12, level0, 20);
    cyc1(); cyc1();
    chk("live_hold_lvl", 14, level0, 20);
    chk("live_hold_busy", 14, busy, 0);
    chk("live_hold_key", 14, key_idx, 0);
    enable = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_fade_sequencer.md
# rgb_fade_sequencer

Sequencer for the three PWM duty levels of the RGB mixer. Cycles through a small table of host-written colour keyframes and ramps each channel one LSB per step toward the current target. Holds at each keyframe, then advances. Sits between the encoder-derived levels and the three PWM generators; a mode select hands control back to the encoders without a jump in level.

## Interface
Parameters:
- NUM_KEYS, 4, number of keyframes (power of two, ≥2)
- WIDTH, 8, duty-level width per channel
- DIV_W, 16, width of step divider

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = sequencer runs; 0 = freeze
- seq_sel  in  1  1 = sequencer drives outputs; 0 = encoder pass-through
- enc_level0/1/2  in  WIDTH each  encoder-derived levels
- key_we  in  1  keyframe write strobe
- key_addr  in  log2(NUM_KEYS)  keyframe index
- key_rgb  in  3*WIDTH  {ch2,ch1,ch0} target levels
- step_div  in  DIV_W  clocks per ramp step minus one
- hold_steps  in  8  ticks to hold at keyframe
- level0/1/2  out  WIDTH each  duty levels to PWM blocks
- key_idx  out  log2(NUM_KEYS)  current target keyframe
- busy  out  1  high in RAMP

## Operation
- Reset: keyframe table all 0, level0..2=0, key_idx=0, state IDLE, prescaler=0, hold counter=0, busy=0.
- Prescaler counts 0..step_div; tick asserted for one cycle when count==step_div, then wraps to 0. step_div=0 → tick every cycle. Runs only in RAMP/HOLD; cleared on entry to RAMP from IDLE.
- States:
  - IDLE: levels hold. enable=1 and seq_sel=1 → RAMP.
  - RAMP: on tick, each channel whose level ≠ target moves ±1 toward target (no overshoot, no wrap). When all three equal target (checked every cycle) → HOLD, hold counter=0.
  - HOLD: on tick, if hold counter==hold_steps → key_idx increments (NUM_KEYS-1 wraps to 0), → RAMP; else hold counter+1. hold_steps=0 → exits on first tick.
  - Any state: enable=0 or seq_sel=0 → IDLE next cycle; key_idx, hold counter, levels retained.
- seq_sel=0: each cycle the internal level registers load enc_level0..2, so the return to sequencer mode starts from the encoder values.
- Keyframe write: key_we stores key_rgb at key_addr the next edge. Writing the current target takes effect on the following cycle's comparison. A write during reset is ignored.
- Simultaneous: a key_we to the current target in the same cycle as the RAMP→HOLD decision uses the old target. The new one is seen in HOLD and applies on the next RAMP.

## Timing
- All outputs registered; no combinational path input→output.
- Level change appears the cycle after the tick.
- Encoder pass-through latency 1 cycle.
- Full 0→255 ramp with step_div=0: 255 cycles of RAMP, HOLD entered on cycle 256.
- Per step period = step_div+1 cycles. Hold duration = (hold_steps+1)·(step_div+1) cycles, measured from HOLD entry with prescaler continuing.
- busy tracks state with 1 cycle registration (high the cycle after RAMP entry).

## Structure
- Package rgb_seq_pkg: state enum {IDLE, RAMP, HOLD}, WIDTH default, key-index width function.
- Sub-module rgb_ramp_channel, instantiated ×3: holds one level register. Inputs: step enable, target, load, load value. Outputs: level and at_target.
- Top holds the FSM, prescaler, hold counter and keyframe table (flops, NUM_KEYS×3×WIDTH).

## Test plan
- Reset then check idle: assert reset mid-RAMP → next cycle level0..2=0, key_idx=0, busy=0, table reads back 0 via subsequent ramp staying at 0.
- Single ramp: key0=(10,0,5), step_div=0, enable=seq_sel=1 → level0 reaches 10 after 10 ticks, level2 holds 5 from tick 5 on, HOLD on cycle 11.
- Prescaler and hold: step_div=3, hold_steps=2, key0=(4,4,4), key1=(0,0,0) → each step 4 cycles apart. HOLD lasts 12 cycles, then key_idx=1 and levels ramp down to 0.
- Wrap: NUM_KEYS=4, all keys distinct → key_idx sequence 0,1,2,3,0.
- Bumpless handover: seq_sel=0, enc_level=(200,100,50) for ≥2 cycles, then seq_sel=1 with key0=(202,100,50) → outputs step 200→201→202 on level0 only.
- Live edit: during RAMP toward key0=(100,…), rewrite key0 to (20,…) when level0=30 → level0 reverses and settles at 20.
